// File: rtl/fetch_stage.sv
// fetch_stage: RV32I instruction fetch. Owns the PC, drives word addresses to the
// BIOS and IMEM synchronous-read memories, and presents {if_pc, if_inst, if_valid}
// to decode. A stall is absorbed by a hold register. A redirect squashes the word
// currently on the output.
//
// Ports:
//   clk, rst           clock; synchronous active-high reset
//   stall              downstream not accepting; hold current output
//   redirect_valid/pc  take redirect target this cycle (bits [1:0] ignored)
//   bios_addr/dout     BIOS word address / read data (1-cycle latency)
//   imem_addr/dout     IMEM word address / read data (1-cycle latency)
//   if_pc/inst/valid   fetched instruction presented to decode
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h4000_0000,
  parameter int unsigned BIOS_AW  = 12,
  parameter int unsigned IMEM_AW  = 14,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  output logic [BIOS_AW-1:0] bios_addr,
  input  logic [31:0]        bios_dout,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_dout,
  output logic [31:0]        if_pc,
  output logic [31:0]        if_inst,
  output logic               if_valid
);

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } state_e;

  // pc_q is the address whose read data is returning this cycle
  logic [31:0] pc_q, pc_d;
  state_e      st_q, st_d;
  logic [31:0] hold_q, hold_d;
  logic        kill_q, kill_d;

  logic [31:0] fetch_addr;
  logic [31:0] mem_inst;

  // Next fetch address, highest priority first
  always_comb begin
    if (rst) begin
      fetch_addr = RESET_PC;
    end else if (redirect_valid) begin
      fetch_addr = redirect_pc & ~32'd3;
    end else if (stall) begin
      fetch_addr = pc_q;
    end else begin
      fetch_addr = pc_q + 32'd4;
    end
  end

  assign bios_addr = fetch_addr[BIOS_AW+1:2];
  assign imem_addr = fetch_addr[IMEM_AW+1:2];

  // Select returning word by region of the address that produced it
  always_comb begin
    case (pc_q[31:28])
      4'b0100: mem_inst = bios_dout;
      4'b0001: mem_inst = imem_dout;
      default: mem_inst = NOP_INST;
    endcase
  end

  // Next-state logic: redirect beats stall; HOLD keeps the word captured on
  // the first stall cycle so later memory writes cannot disturb the output
  always_comb begin
    pc_d   = fetch_addr;
    st_d   = st_q;
    hold_d = hold_q;
    kill_d = 1'b0;
    if (redirect_valid) begin
      st_d = RUN;
    end else begin
      case (st_q)
        RUN: begin
          if (stall) begin
            st_d   = HOLD;
            hold_d = mem_inst;
          end
        end
        HOLD: begin
          if (!stall) st_d = RUN;
        end
        default: st_d = RUN;
      endcase
    end
  end

  // State register; reset overrides any stall or redirect on the same edge
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q   <= RESET_PC;
      st_q   <= RUN;
      hold_q <= NOP_INST;
      kill_q <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      st_q   <= st_d;
      hold_q <= hold_d;
      kill_q <= kill_d;
    end
  end

  // Output presentation; squashed slots always carry a NOP
  assign if_pc    = pc_q;
  assign if_valid = ~rst & ~redirect_valid & ~kill_q;
  assign if_inst  = !if_valid      ? NOP_INST :
                    (st_q == HOLD) ? hold_q   : mem_inst;

endmodule
